// File: rtl/start_bit_validator.sv
// Start-bit validator: arms after a run of idle-high ticks, flags an armed falling
// edge, then confirms or rejects the start bit with a mid-bit (majority) sample.
module start_bit_validator #(
  parameter int OVERSAMPLE = 16,
  parameter int IDLE_MIN   = 2,
  parameter int MAJORITY   = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic serial_in_synced,
  input  logic sample_tick,
  input  logic rx_busy,
  output logic start_detected,
  output logic start_valid,
  output logic false_start,
  output logic armed
);

  localparam int MID = OVERSAMPLE / 2;
  localparam int CW  = $clog2(OVERSAMPLE);
  localparam int IW  = $clog2(IDLE_MIN + 1);
  localparam logic [CW-1:0] MID_M1 = CW'(MID - 1);
  localparam logic [CW-1:0] MID_C  = CW'(MID);
  localparam logic [IW-1:0] IDLE_C = IW'(IDLE_MIN);

  typedef enum logic [1:0] {ARM_WAIT, IDLE, CHECK} state_t;

  state_t        state, state_n;
  logic [IW-1:0] idle_cnt, idle_cnt_n, idle_inc;
  logic [CW-1:0] tick_cnt, tick_cnt_n, tick_inc;
  logic [1:0]    vote, vote_n;
  logic          prev_line, fall, line;
  logic          det_n, val_n, fs_n;

  assign line     = serial_in_synced;
  assign fall     = prev_line & ~line;
  assign idle_inc = idle_cnt + IW'(1);
  assign tick_inc = tick_cnt + CW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ARM_WAIT;
      idle_cnt       <= '0;
      tick_cnt       <= '0;
      vote           <= '0;
      prev_line      <= 1'b1;
      start_detected <= 1'b0;
      start_valid    <= 1'b0;
      false_start    <= 1'b0;
    end else begin
      state          <= state_n;
      idle_cnt       <= idle_cnt_n;
      tick_cnt       <= tick_cnt_n;
      vote           <= vote_n;
      prev_line      <= line;
      start_detected <= det_n;
      start_valid    <= val_n;
      false_start    <= fs_n;
    end
  end

  always_comb begin
    state_n    = state;
    idle_cnt_n = idle_cnt;
    tick_cnt_n = tick_cnt;
    vote_n     = vote;
    det_n      = 1'b0;
    val_n      = 1'b0;
    fs_n       = 1'b0;
    case (state)
      ARM_WAIT: begin
        if (sample_tick) begin
          if (line && !rx_busy) begin
            if (idle_inc == IDLE_C) begin
              state_n    = IDLE;
              idle_cnt_n = '0;
            end else begin
              idle_cnt_n = idle_inc;
            end
          end else begin
            idle_cnt_n = '0;
          end
        end
      end
      IDLE: begin
        // A coincident sample_tick is deliberately not counted on the edge clk
        if (fall) begin
          if (rx_busy) begin
            state_n    = ARM_WAIT;
            idle_cnt_n = '0;
          end else begin
            state_n    = CHECK;
            tick_cnt_n = '0;
            det_n      = 1'b1;
          end
        end
      end
      CHECK: begin
        if (sample_tick) begin
          tick_cnt_n = tick_inc;
          if (MAJORITY != 0) begin
            if (tick_inc < MID_M1) begin
              fs_n = line;
            end else if (tick_inc == MID_M1) begin
              vote_n[0] = line;
            end else if (tick_inc == MID_C) begin
              vote_n[1] = line;
            end else begin
              // At least two of the three mid-bit samples must be low
              if ((!vote[0] && !vote[1]) || (!line && (!vote[0] || !vote[1])))
                val_n = 1'b1;
              else
                fs_n = 1'b1;
            end
          end else begin
            if (tick_inc < MID_C) fs_n = line;
            else begin
              val_n = ~line;
              fs_n  = line;
            end
          end
          if (val_n || fs_n) begin
            state_n    = ARM_WAIT;
            tick_cnt_n = '0;
            idle_cnt_n = '0;
            vote_n     = '0;
          end
        end
      end
      default: state_n = ARM_WAIT;
    endcase
  end

  always_comb begin
    armed = (state == IDLE);
  end

endmodule

// File: tb/tb_start_bit_validator.sv
// Scoreboarded bench: directed stimulus queues expected pulses per DUT, a negedge
// monitor pops and compares them. dut1 uses MAJORITY=1, dut0 uses MAJORITY=0.
module tb_start_bit_validator;

  logic clk = 1'b0;
  logic rst_n, line_a, line_b, tick, busy;
  logic det1, val1, fs1, armed1;
  logic det0, val0, fs0, armed0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   sel_b = 1'b0;

  typedef struct {
    logic [2:0] ev;
    int         cyc;
  } exp_t;

  localparam logic [2:0] DET = 3'b001, VAL = 3'b010, FS = 3'b100;

  exp_t q[2][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  start_bit_validator #(.OVERSAMPLE(16), .IDLE_MIN(2), .MAJORITY(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .serial_in_synced(line_a), .sample_tick(tick),
    .rx_busy(busy), .start_detected(det1), .start_valid(val1),
    .false_start(fs1), .armed(armed1));

  start_bit_validator #(.OVERSAMPLE(16), .IDLE_MIN(2), .MAJORITY(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .serial_in_synced(line_b), .sample_tick(tick),
    .rx_busy(busy), .start_detected(det0), .start_valid(val0),
    .false_start(fs0), .armed(armed0));

  // Monitor: any pulse must match the head of that DUT's queue
  always @(negedge clk) begin
    logic [2:0] ev [2];
    exp_t e;
    ev[0] = {fs1, val1, det1};
    ev[1] = {fs0, val0, det0};
    for (int d = 0; d < 2; d++) begin
      if (ev[d] != 3'b000) begin
        checks++;
        if ($countones(ev[d]) != 1) begin
          errors++;
          $display("FAIL overlap q%0d: got ev=%b at cyc %0d, required one-hot", d, ev[d], cyc);
        end else if (q[d].size() == 0) begin
          errors++;
          $display("FAIL unexpected q%0d: got ev=%b at cyc %0d, required none", d, ev[d], cyc);
        end else begin
          e = q[d].pop_front();
          if (e.ev != ev[d] || e.cyc != cyc) begin
            errors++;
            $display("FAIL event q%0d: got ev=%b cyc=%0d, required ev=%b cyc=%0d",
                     d, ev[d], cyc, e.ev, e.cyc);
          end
        end
      end
    end
  end

  task automatic expect_ev(input int d, input logic [2:0] ev);
    exp_t e;
    e.ev  = ev;
    e.cyc = cyc + 1;
    q[d].push_back(e);
  endtask

  task automatic drive(input logic l, input logic t, input logic b);
    if (sel_b) line_b = l;
    else       line_a = l;
    tick = t;
    busy = b;
    @(posedge clk);
    #1;
  endtask

  task automatic period(input logic l);
    drive(l, 1'b1, 1'b0);
    repeat (3) drive(l, 1'b0, 1'b0);
  endtask

  task automatic chk_armed(input int d, input logic exp_v, input string name);
    logic act;
    act = (d == 0) ? armed1 : armed0;
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: armed got %b, required %b", name, act, exp_v);
    end
  endtask

  // Edge on a non-tick clk, then 16 bit-ticks; dec_tick is where the decision lands
  task automatic clean_start(input int d, input int dec_tick, input int high_tick);
    expect_ev(d, DET);
    drive(1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 16; k++) begin
      if (k == dec_tick) expect_ev(d, VAL);
      period(k == high_tick);
    end
    chk_armed(d, 1'b0, "disarmed_after_start");
    period(1'b1);
    period(1'b1);
    chk_armed(d, 1'b1, "rearm_after_start");
  endtask

  initial begin
    rst_n  = 1'b0;
    line_a = 1'b0;
    line_b = 1'b1;
    tick   = 1'b0;
    busy   = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Line held low through reset release: never arms, never detects
    chk_armed(0, 1'b0, "reset_armed");
    repeat (10) period(1'b0);
    chk_armed(0, 1'b0, "low_after_reset");
    period(1'b1);
    chk_armed(0, 1'b0, "one_high_tick");
    period(1'b1);
    chk_armed(0, 1'b1, "armed_after_idle");

    // Clean start: valid 1 clk after tick 9
    clean_start(0, 9, 0);

    // Glitch: low for 3 ticks, high at tick 4 aborts
    expect_ev(0, DET);
    drive(1'b0, 1'b0, 1'b0);
    repeat (3) period(1'b0);
    expect_ev(0, FS);
    period(1'b1);
    chk_armed(0, 1'b0, "glitch_disarmed");
    period(1'b1);
    period(1'b1);
    chk_armed(0, 1'b1, "glitch_rearm");

    // Single high sample at tick 8 still votes 2/3 low
    clean_start(0, 9, 8);

    // Busy: line high stays armed; a busy fall drops back to ARM_WAIT
    drive(1'b1, 1'b1, 1'b1);
    drive(1'b1, 1'b0, 1'b1);
    chk_armed(0, 1'b1, "busy_high_stays_idle");
    drive(1'b0, 1'b0, 1'b1);
    chk_armed(0, 1'b0, "busy_fall_disarms");
    period(1'b1);
    period(1'b1);
    chk_armed(0, 1'b1, "busy_rearm");

    // Reset at tick 5 of CHECK
    expect_ev(0, DET);
    drive(1'b0, 1'b0, 1'b0);
    repeat (5) period(1'b0);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({det1, val1, fs1, armed1} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_mid_check: outputs got %b, required 0000", {det1, val1, fs1, armed1});
    end
    line_a = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    period(1'b1);
    period(1'b1);
    chk_armed(0, 1'b1, "rearm_after_reset");
    clean_start(0, 9, 0);

    // MAJORITY=0 instance: valid 1 clk after tick 8
    chk_armed(1, 1'b1, "maj0_armed");
    sel_b = 1'b1;
    clean_start(1, 8, 0);

    repeat (4) drive(1'b1, 1'b0, 1'b0);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (q[d].size() != 0) begin
        errors++;
        $display("FAIL missing q%0d: got %0d pending, required 0", d, q[d].size());
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
